// File: rtl/puf_batch_cntrlr.sv
// PUF batch controller: buffers NUM_CH challenge words, then runs execute/transmit
// per challenge with resumable, edge-triggered dump interrupts and an EXEC timeout.
module puf_batch_cntrlr #(
  parameter int MUX_LENGTH = 16,
  parameter int NUM_CH     = 4,
  parameter int TIMEOUT    = 255,
  localparam int SEL_W = $clog2(MUX_LENGTH),
  localparam int CH_W  = $clog2(NUM_CH),
  localparam int TO_W  = $clog2(TIMEOUT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_op_mode,
  input  logic               i_rx_valid,
  input  logic [2*SEL_W-1:0] i_rx_data,
  output logic               o_rx_ready,
  input  logic               i_exec_done,
  input  logic               i_tx_done,
  output logic               o_exec_enable,
  output logic               o_tx_enable,
  output logic               o_dump_enable,
  output logic [SEL_W-1:0]   o_sel_mux_0,
  output logic [SEL_W-1:0]   o_sel_mux_1,
  output logic [CH_W-1:0]    o_ch_idx,
  output logic [2:0]         o_fsm_state,
  output logic               o_timeout,
  output logic               o_busy
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_EXEC = 3'd2,
    ST_TX   = 3'd3,
    ST_DUMP = 3'd4
  } state_e;

  state_e             state_q, state_d, ret_q;
  logic [2*SEL_W-1:0] buf_q [NUM_CH];
  logic [CH_W-1:0]    wr_idx_q, ch_idx_q;
  logic [TO_W-1:0]    tmo_cnt_q;
  logic               pend_q, op_mode_q, timeout_q;
  logic               rx_fire, last_wr, last_ch, tmo_hit, tmo_set, op_rise, take_dump;
  logic [2*SEL_W-1:0] cur_word;
  logic               sel_on;

  // Receive handshake: a word transfers on a rising clk edge where i_rx_valid and
  // o_rx_ready are both high; ready depends only on state, never on valid.
  assign rx_fire = (state_q == ST_LOAD) && i_rx_valid;
  assign last_wr = (wr_idx_q == CH_W'(NUM_CH - 1));
  assign last_ch = (ch_idx_q == CH_W'(NUM_CH - 1));
  assign tmo_hit = (tmo_cnt_q == TO_W'(TIMEOUT - 1));
  assign op_rise = i_op_mode && !op_mode_q;

  always_comb begin
    state_d = state_q;
    tmo_set = 1'b0;
    case (state_q)
      ST_IDLE: if (i_start) state_d = ST_LOAD;
      ST_LOAD: if (rx_fire && last_wr) state_d = ST_EXEC;
      ST_EXEC: begin
        if (i_exec_done) begin
          state_d = ST_TX;
        end else if (tmo_hit) begin
          state_d = ST_TX;
          tmo_set = 1'b1;
        end
      end
      ST_TX:   if (i_tx_done) state_d = last_ch ? ST_IDLE : ST_EXEC;
      ST_DUMP: if (i_tx_done) state_d = ret_q;
      default: state_d = ST_IDLE;
    endcase
  end

  // A pending dump preempts LOAD/EXEC at once, but TX only on its tx_done boundary.
  assign take_dump = pend_q && ((state_q == ST_LOAD) || (state_q == ST_EXEC) ||
                                ((state_q == ST_TX) && i_tx_done));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ret_q     <= ST_IDLE;
      wr_idx_q  <= '0;
      ch_idx_q  <= '0;
      tmo_cnt_q <= '0;
      pend_q    <= 1'b0;
      op_mode_q <= 1'b0;
      timeout_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) buf_q[i] <= '0;
    end else begin
      op_mode_q <= i_op_mode;
      if (take_dump) begin
        state_q <= ST_DUMP;
        ret_q   <= state_d;
        pend_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        if (op_rise && (state_q != ST_IDLE) && (state_q != ST_DUMP)) pend_q <= 1'b1;
      end
      tmo_cnt_q <= ((state_q == ST_EXEC) && (state_d == ST_EXEC) && !take_dump)
                   ? tmo_cnt_q + TO_W'(1) : '0;
      if ((state_q == ST_IDLE) && i_start) begin
        wr_idx_q  <= '0;
        ch_idx_q  <= '0;
        timeout_q <= 1'b0;
      end
      if (rx_fire) begin
        buf_q[wr_idx_q] <= i_rx_data;
        wr_idx_q        <= wr_idx_q + CH_W'(1);
        if (last_wr) ch_idx_q <= '0;
      end
      if (tmo_set) timeout_q <= 1'b1;
      if ((state_q == ST_TX) && i_tx_done && !last_ch) ch_idx_q <= ch_idx_q + CH_W'(1);
    end
  end

  assign cur_word = buf_q[ch_idx_q];
  assign sel_on   = (state_q == ST_EXEC) || (state_q == ST_TX) || (state_q == ST_DUMP);

  assign o_sel_mux_0   = sel_on ? cur_word[SEL_W-1:0] : '0;
  assign o_sel_mux_1   = sel_on ? cur_word[2*SEL_W-1:SEL_W] : '0;
  assign o_rx_ready    = (state_q == ST_LOAD);
  assign o_exec_enable = (state_q == ST_EXEC);
  assign o_tx_enable   = (state_q == ST_TX);
  assign o_dump_enable = (state_q == ST_DUMP);
  assign o_busy        = (state_q != ST_IDLE);
  assign o_fsm_state   = state_q;
  assign o_ch_idx      = ch_idx_q;
  assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_puf_batch_cntrlr.sv
// Randomized bench for puf_batch_cntrlr: scenario tasks predict the state sequence
// from the batch/dump/timeout rules, and a word queue predicts the selects.
module tb_puf_batch_cntrlr;
  localparam int MUX_LENGTH = 16;
  localparam int NUM_CH     = 4;
  localparam int TIMEOUT    = 255;
  localparam int SEL_W      = 4;
  localparam int CH_W       = 2;
  localparam int W          = 2 * SEL_W;
  localparam int S_IDLE = 0, S_LOAD = 1, S_EXEC = 2, S_TX = 3, S_DUMP = 4;

  logic clk = 1'b0;
  logic rst, i_start, i_op_mode, i_rx_valid, i_exec_done, i_tx_done;
  logic [W-1:0] i_rx_data;
  logic o_rx_ready, o_exec_enable, o_tx_enable, o_dump_enable, o_timeout, o_busy;
  logic [SEL_W-1:0] o_sel_mux_0, o_sel_mux_1;
  logic [CH_W-1:0] o_ch_idx;
  logic [2:0] o_fsm_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic exp_to;
  logic [W-1:0] wv [NUM_CH];
  int ex [NUM_CH];
  int tx [NUM_CH];

  puf_batch_cntrlr #(.MUX_LENGTH(MUX_LENGTH), .NUM_CH(NUM_CH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_op_mode(i_op_mode),
    .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data), .o_rx_ready(o_rx_ready),
    .i_exec_done(i_exec_done), .i_tx_done(i_tx_done), .o_exec_enable(o_exec_enable),
    .o_tx_enable(o_tx_enable), .o_dump_enable(o_dump_enable),
    .o_sel_mux_0(o_sel_mux_0), .o_sel_mux_1(o_sel_mux_1), .o_ch_idx(o_ch_idx),
    .o_fsm_state(o_fsm_state), .o_timeout(o_timeout), .o_busy(o_busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_outs(input int st);
    check_eq("state", 32'(o_fsm_state), 32'(st));
    check_eq("busy", 32'(o_busy), 32'(st != S_IDLE));
    check_eq("rx_ready", 32'(o_rx_ready), 32'(st == S_LOAD));
    check_eq("exec_en", 32'(o_exec_enable), 32'(st == S_EXEC));
    check_eq("tx_en", 32'(o_tx_enable), 32'(st == S_TX));
    check_eq("dump_en", 32'(o_dump_enable), 32'(st == S_DUMP));
    check_eq("timeout", 32'(o_timeout), 32'(exp_to));
    if (st == S_IDLE || st == S_LOAD) begin
      check_eq("sel0_zero", 32'(o_sel_mux_0), 32'd0);
      check_eq("sel1_zero", 32'(o_sel_mux_1), 32'd0);
    end
  endtask

  task automatic check_sel(input logic [W-1:0] wd, input int idx);
    check_eq("sel0", 32'(o_sel_mux_0), 32'(wd[SEL_W-1:0]));
    check_eq("sel1", 32'(o_sel_mux_1), 32'(wd[W-1:SEL_W]));
    check_eq("ch_idx", 32'(o_ch_idx), 32'(idx));
  endtask

  // driver tasks
  task automatic quiet();
    i_start = 1'b0; i_rx_valid = 1'b0; i_exec_done = 1'b0; i_tx_done = 1'b0;
  endtask

  task automatic noise();
    i_start    = 1'($urandom_range(0, 1));
    i_rx_valid = 1'($urandom_range(0, 1));
    i_rx_data  = W'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1; i_op_mode = 1'b0; i_rx_data = '0; quiet();
    tick(); tick();
    rst = 1'b0; exp_to = 1'b0; exp_q.delete();
    check_outs(S_IDLE);
    check_eq("ch_idx_rst", 32'(o_ch_idx), 32'd0);
  endtask

  task automatic dump_phase(input int ret, input logic [W-1:0] wd, input int idx);
    int d;
    d = $urandom_range(0, 3);
    for (int k = 0; k <= d; k++) begin
      check_outs(S_DUMP);
      check_sel(wd, idx);
      noise();
      i_exec_done = 1'($urandom_range(0, 1));
      i_tx_done   = (k == d);
      tick(); quiet();
    end
    check_outs(ret);
  endtask

  task automatic run_batch(input logic [W-1:0] words [NUM_CH], input int exl [NUM_CH],
                           input int txl [NUM_CH], input bit ld, input int xd_ch,
                           input int xd_at, input int td_ch);
    check_outs(S_IDLE);
    i_start = 1'b1; tick(); i_start = 1'b0; exp_to = 1'b0;
    check_outs(S_LOAD);
    for (int w = 0; w < NUM_CH; w++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        i_start = 1'($urandom_range(0, 1)); i_rx_data = W'($urandom);
        tick(); quiet();
        check_outs(S_LOAD);
      end
      i_rx_valid = 1'b1; i_rx_data = words[w]; exp_q.push_back(words[w]);
      tick(); quiet();
      check_outs((w < NUM_CH - 1) ? S_LOAD : S_EXEC);
      if (ld && w == 1) begin
        i_op_mode = 1'b1;
        tick(); check_outs(S_LOAD);
        tick(); check_outs(S_DUMP);
        dump_phase(S_LOAD, words[0], 0);
      end
    end
    i_op_mode = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      logic [W-1:0] wd;
      int n;
      bit dumped, dn, pend;
      int nxt;
      wd = exp_q.pop_front(); n = 0; dumped = 0; pend = 0;
      for (int guard = 0; guard < 3 * TIMEOUT; guard++) begin
        check_outs(S_EXEC);
        check_sel(wd, c);
        n++;
        dn = (exl[c] != 0) && (n == exl[c]);
        noise();
        i_tx_done = 1'($urandom_range(0, 1));
        i_exec_done = dn;
        if (c == xd_ch && !dumped && n == xd_at) i_op_mode = 1'b1;
        tick(); quiet();
        if (c == xd_ch && !dumped && n == xd_at + 1) begin
          dumped = 1; check_outs(S_DUMP); i_op_mode = 1'b0;
          dump_phase(S_EXEC, wd, c);
          n = 0;
        end else if (dn) begin
          check_outs(S_TX); break;
        end else if (n >= TIMEOUT) begin
          exp_to = 1'b1; check_outs(S_TX); break;
        end
      end
      for (int m = 1; m <= txl[c]; m++) begin
        check_outs(S_TX);
        check_sel(wd, c);
        if (c == td_ch && m == 1) begin i_op_mode = 1'b1; pend = 1; end
        noise();
        i_exec_done = 1'($urandom_range(0, 1));
        i_tx_done = (m == txl[c]);
        tick(); quiet();
      end
      nxt = (c == NUM_CH - 1) ? S_IDLE : S_EXEC;
      if (pend) begin
        check_outs(S_DUMP); i_op_mode = 1'b0;
        if (c == NUM_CH - 1) dump_phase(nxt, wd, c);
        else dump_phase(nxt, exp_q[0], c + 1);
      end else begin
        check_outs(nxt);
      end
    end
    for (int k = 0; k < 3; k++) begin
      i_op_mode = 1'($urandom_range(0, 1)); i_rx_valid = 1'($urandom_range(0, 1));
      i_exec_done = 1'($urandom_range(0, 1)); i_tx_done = 1'($urandom_range(0, 1));
      tick(); quiet();
      check_outs(S_IDLE);
    end
    i_op_mode = 1'b0;
    tick();
  endtask

  task automatic reset_in_dump();
    check_outs(S_IDLE);
    i_start = 1'b1; tick(); i_start = 1'b0; exp_to = 1'b0;
    check_outs(S_LOAD);
    for (int w = 0; w < 2; w++) begin
      i_rx_valid = 1'b1; i_rx_data = W'($urandom);
      tick(); quiet();
      check_outs(S_LOAD);
    end
    i_op_mode = 1'b1;
    tick(); check_outs(S_LOAD);
    tick(); check_outs(S_DUMP);
    tick(); check_outs(S_DUMP);
    rst = 1'b1; i_op_mode = 1'b0;
    tick(); rst = 1'b0;
    exp_q.delete();
    check_outs(S_IDLE);
    check_eq("ch_idx_rst_dump", 32'(o_ch_idx), 32'd0);
  endtask

  task automatic rand_batch();
    bit ld;
    int xd_ch, xd_at, td_ch, r;
    for (int c = 0; c < NUM_CH; c++) begin
      wv[c] = W'($urandom);
      r = $urandom_range(0, 9);
      ex[c] = (r == 0) ? 0 : (r == 1) ? TIMEOUT : $urandom_range(1, 6);
      tx[c] = $urandom_range(2, 4);
    end
    ld    = 1'($urandom_range(0, 1));
    xd_ch = int'($urandom_range(0, 4)) - 1;
    xd_at = $urandom_range(2, 4);
    td_ch = int'($urandom_range(0, 4)) - 1;
    if (xd_ch >= 0 && ex[xd_ch] != 0 && ex[xd_ch] < xd_at + 2) ex[xd_ch] = xd_at + 2;
    run_batch(wv, ex, tx, ld, xd_ch, xd_at, td_ch);
  endtask

  initial begin
    do_reset();
    wv = '{8'h21, 8'h43, 8'h65, 8'h87}; ex = '{3, 3, 3, 3}; tx = '{2, 2, 2, 2};
    run_batch(wv, ex, tx, 0, -1, 0, -1);
    ex = '{3, 3, 0, 3};
    run_batch(wv, ex, tx, 0, -1, 0, -1);
    ex = '{3, 0, 3, 3};
    run_batch(wv, ex, tx, 0, 1, 2, -1);
    ex = '{2, 2, 2, 2};
    run_batch(wv, ex, tx, 1, -1, 0, -1);
    tx = '{2, 2, 2, 3};
    run_batch(wv, ex, tx, 0, -1, 0, 3);
    ex = '{TIMEOUT, 1, 1, 1};
    run_batch(wv, ex, tx, 0, -1, 0, -1);
    for (int b = 0; b < 8; b++) rand_batch();
    reset_in_dump();
    rand_batch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #800000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
